// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the single-cycle decode/control unit.
// Holds the PC and issues req/ack reads to instruction memory. Each fetched
// word is presented to decode with a valid/ready handshake. PC redirects
// from the execute side have priority over every ack and accept.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   imem_req/addr       read request and address (addr is the pc register)
//   imem_ack/rdata      memory completion and data, valid in the same cycle
//   instr/instr_pc      fetched word and its PC
//   instr_valid/ready   handshake with decode
//   redirect/_pc        1-cycle redirect pulse and target (low bits forced 0)
//   misalign_err        sticky flag, set by a misaligned redirect target
//   step                (FETCH_STEP_EN only) debug single-step pulse
//
// Build option: define FETCH_STEP_EN to add the `step` input; then each
// accept that leaves HOLD consumes one step (pending or same-cycle).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_STEP_EN
  input  logic        step,
`endif
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] target;
  logic        step_ok;

`ifdef FETCH_STEP_EN
  logic step_pending_q, step_pending_d;
`endif

  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q | (redirect & (redirect_pc[1:0] != 2'b00));
`ifdef FETCH_STEP_EN
    step_ok        = step_pending_q | step;
    step_pending_d = step_pending_q | step;
`else
    step_ok        = 1'b1;
`endif

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else begin
            state_d    = S_HOLD;
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
          end
        end else if (redirect) begin
          // The issued request cannot be withdrawn: keep the address stable
          // and remember where to go once its ack arrives.
          state_d = S_DRAIN;
          pend_d  = target;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          state_d = S_REQ;
          pc_d    = redirect ? target : pend_q;
        end else if (redirect) begin
          pend_d = target;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
          pc_d    = target;
        end else if (instr_ready && step_ok) begin
          state_d = S_REQ;
          pc_d    = pc_q + PC_STEP;
`ifdef FETCH_STEP_EN
          step_pending_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d   = (state_d == S_REQ) || (state_d == S_DRAIN);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

`ifdef FETCH_STEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pending_q <= 1'b0;
    end else begin
      step_pending_q <= step_pending_d;
    end
  end
`endif

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic for instr_fetch,
// checked against a transaction-level reference model of the fetch stage.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(32'h0000_3000),
    .PC_STEP (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .misalign_err(misalign_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding memory read (possibly already killed by
  // a redirect), or one word waiting for decode.
  bit          m_started, m_busy, m_killed, m_have, m_err;
  logic [31:0] m_pc, m_pend, m_instr, m_ipc;
  int          dut_acc_cnt;
  logic [31:0] dut_acc_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_killed = 0; m_have = 0; m_err = 0;
    m_pc = 32'h3000; m_pend = 32'h3000; m_instr = 32'h13; m_ipc = 32'h3000;
  endtask

  task automatic model_step(input logic ack, input logic [31:0] rdata, input logic ready,
                            input logic redir, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    if (redir && rpc[1:0] != 2'b00) m_err = 1;
    if (!m_started) begin
      m_started = 1;
      m_busy    = 1;
    end else if (m_busy && !m_killed) begin
      if (ack && redir) m_pc = tgt;
      else if (ack) begin
        m_busy = 0; m_have = 1; m_instr = rdata; m_ipc = m_pc;
      end else if (redir) begin
        m_killed = 1; m_pend = tgt;
      end
    end else if (m_busy) begin
      if (ack) begin
        m_killed = 0;
        m_pc = redir ? tgt : m_pend;
      end else if (redir) m_pend = tgt;
    end else if (m_have) begin
      if (redir) begin
        m_have = 0; m_busy = 1; m_pc = tgt;
      end else if (ready) begin
        m_have = 0; m_busy = 1; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("imem_req",     {31'b0, imem_req},     {31'b0, m_busy});
    check_eq("imem_addr",    imem_addr,             m_pc);
    check_eq("instr_valid",  {31'b0, instr_valid},  {31'b0, m_have});
    check_eq("instr",        instr,                 m_instr);
    check_eq("instr_pc",     instr_pc,              m_ipc);
    check_eq("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  // Entered and left at a falling edge: compare, drive, advance one clock.
  task automatic cycle(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] rpc);
    compare_outputs();
    imem_ack = ack; imem_rdata = rdata; instr_ready = ready;
    redirect = redir; redirect_pc = rpc;
    if (instr_valid && ready && !redir) begin
      dut_acc_cnt++;
      dut_acc_pc = instr_pc;
    end
    model_step(ack, rdata, ready, redir, rpc);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserted at a falling edge so the asynchronous clear is seen before any
  // rising edge; released at the following falling edge.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 0; instr_ready = 0; redirect = 0; redirect_pc = '0; imem_rdata = '0;
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk);
    compare_outputs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 0; instr_ready = 0; redirect = 0; redirect_pc = '0; imem_rdata = '0;
    dut_acc_cnt = 0; dut_acc_pc = '0;
    @(negedge clk);
    do_reset();

    // Reset release with ack tied to req
    cycle(m_busy, 32'h0050_0093, 1'b0, 1'b0, '0);
    check_eq("s1_req",  {31'b0, imem_req}, 32'd1);
    check_eq("s1_addr", imem_addr, 32'h3000);
    cycle(m_busy, 32'h0050_0093, 1'b0, 1'b0, '0);
    check_eq("s1_valid",    {31'b0, instr_valid}, 32'd1);
    check_eq("s1_instr",    instr, 32'h0050_0093);
    check_eq("s1_instr_pc", instr_pc, 32'h3000);

    // Ten back-to-back accepts
    dut_acc_cnt = 0;
    for (int i = 0; i < 100 && dut_acc_cnt < 10; i++)
      cycle(m_busy, 32'h0050_0093, 1'b1, 1'b0, '0);
    check_eq("s2_accepts",  dut_acc_cnt, 32'd10);
    check_eq("s2_last_pc",  dut_acc_pc, 32'h3024);
    check_eq("s2_next_addr", imem_addr, 32'h3028);

    // Decode stalls in HOLD, then exactly one accept
    cycle(m_busy, 32'h1234_5678, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, '0);
    check_eq("s3_instr", instr, 32'h1234_5678);
    check_eq("s3_req",   {31'b0, imem_req}, 32'd0);
    dut_acc_cnt = 0;
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(m_busy, 32'h0000_0033, 1'b0, 1'b0, '0);
    check_eq("s3_one_accept", dut_acc_cnt, 32'd1);

    // Redirect while the request is outstanding
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h3100);
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("s4_addr_held", imem_addr, 32'h3000);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    check_eq("s4_addr_new", imem_addr, 32'h3100);
    check_eq("s4_no_valid", {31'b0, instr_valid}, 32'd0);
    cycle(m_busy, 32'h0050_0093, 1'b0, 1'b0, '0);
    check_eq("s4_instr_pc", instr_pc, 32'h3100);

    // Misaligned redirect in HOLD with ready high
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h3106);
    check_eq("s5_addr",  imem_addr, 32'h3104);
    check_eq("s5_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("s5_err",   {31'b0, misalign_err}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(m_busy, 32'h0050_0093, 1'b1, 1'b0, '0);
    check_eq("s5_err_sticky", {31'b0, misalign_err}, 32'd1);

    // PC wrap at the top of the address space
    for (int i = 0; i < 10 && !m_have; i++) cycle(m_busy, 32'h13, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 32'h0000_0093, 1'b0, 1'b0, '0);
    check_eq("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b1, 1'b0, '0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset while draining a killed request
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h3200);
    check_eq("s6_drain_addr", imem_addr, 32'h0);
    do_reset();
    check_eq("s6_err_clr", {31'b0, misalign_err}, 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
    check_eq("s6_refetch", imem_addr, 32'h3000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, 32'h3000 + $urandom_range(0, 1023));
    end
    compare_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
